// File: rtl/cfu_mulacc_arbiter_if.sv
// Bus bundle between N_REQ requesters, the arbiter and the shared
// multiply-accumulate CFU. The slave modport is the arbiter's view; the
// master modport is the environment's view (requesters plus the CFU).
//
// Handshake: a requester holds m_req_valid[k] and its operands stable until
// it sees m_req_ready[k]; the request is issued in the cycle where
// m_req_valid[k] & m_req_ready[k] is high. m_req_ready may depend on
// m_req_valid in the same cycle. There is no response back-pressure:
// m_resp_valid[k] is a one-cycle pulse that must be consumed when it appears.
`timescale 1ns/1ps

interface cfu_mulacc_arbiter_if #(
  parameter int N_REQ           = 4,
  parameter int CFU_FUNC_ID_W   = 1,
  parameter int CFU_REQ_DATA_W  = 32,
  parameter int CFU_RESP_DATA_W = 32,
  parameter int CFU_ERR_ID_W    = 32
);
  // requester side
  logic [N_REQ-1:0]                m_req_valid;
  logic [N_REQ-1:0]                m_req_ready;
  logic [N_REQ-1:0]                m_req_lock;
  logic [N_REQ*CFU_FUNC_ID_W-1:0]  m_req_func_id;
  logic [N_REQ*CFU_REQ_DATA_W-1:0] m_req_data0;
  logic [N_REQ*CFU_REQ_DATA_W-1:0] m_req_data1;
  logic [N_REQ-1:0]                m_resp_valid;
  logic [CFU_RESP_DATA_W-1:0]      m_resp_data;
  logic                            m_resp_err;
  logic [CFU_ERR_ID_W-1:0]         m_resp_err_id;

  // CFU side
  logic                            cfu_req_valid;
  logic [CFU_FUNC_ID_W-1:0]        cfu_req_func_id;
  logic [CFU_REQ_DATA_W-1:0]       cfu_req_data0;
  logic [CFU_REQ_DATA_W-1:0]       cfu_req_data1;
  logic                            cfu_resp_valid;
  logic [CFU_RESP_DATA_W-1:0]      cfu_resp_data;
  logic                            cfu_resp_err;
  logic [CFU_ERR_ID_W-1:0]         cfu_resp_err_id;

  modport slave (
    input  m_req_valid, m_req_lock, m_req_func_id, m_req_data0, m_req_data1,
    input  cfu_resp_valid, cfu_resp_data, cfu_resp_err, cfu_resp_err_id,
    output m_req_ready, m_resp_valid, m_resp_data, m_resp_err, m_resp_err_id,
    output cfu_req_valid, cfu_req_func_id, cfu_req_data0, cfu_req_data1
  );

  modport master (
    output m_req_valid, m_req_lock, m_req_func_id, m_req_data0, m_req_data1,
    output cfu_resp_valid, cfu_resp_data, cfu_resp_err, cfu_resp_err_id,
    input  m_req_ready, m_resp_valid, m_resp_data, m_resp_err, m_resp_err_id,
    input  cfu_req_valid, cfu_req_func_id, cfu_req_data0, cfu_req_data1
  );
endinterface

// File: rtl/cfu_mulacc_arbiter.sv
// Round-robin arbiter sharing one pipelined, fixed-latency, stateful
// multiply-accumulate CFU among N_REQ requesters. Grants are combinational
// (no added request latency); a tag pipeline as deep as the CFU latency
// routes each response back to its issuer. A requester issuing with lock=1
// keeps exclusive ownership until it issues a request with lock=0.
// Optional feature macro: CFU_ARB_STATS_EN adds per-requester saturating
// 16-bit issue counters on output stat_issued.
`timescale 1ns/1ps

module cfu_mulacc_arbiter #(
  parameter int N_REQ            = 4,
  parameter int CFU_FUNC_ID_W    = 1,
  parameter int CFU_REQ_DATA_W   = 32,
  parameter int CFU_RESP_DATA_W  = 32,
  parameter int CFU_ERR_ID_W     = 32,
  parameter int CFU_RESP_LATENCY = 3,
  localparam int IDX_W           = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  cfu_mulacc_arbiter_if.slave bus,
  output logic             dbg_locked,
  output logic [IDX_W-1:0] dbg_owner,
  output logic [IDX_W-1:0] dbg_rr_ptr,
  output logic             proto_err
`ifdef CFU_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] stat_issued
`endif
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  int               sum;

  logic [CFU_RESP_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]            tag_idx_q [CFU_RESP_LATENCY];
  logic [IDX_W-1:0]            tag_idx_d [CFU_RESP_LATENCY];

  logic proto_err_q, proto_err_d;

  // Grant selection: owner only while locked, else first valid from rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    sum       = 0;
    if (state_q == ST_LOCKED) begin
      if (bus.m_req_valid[owner_q]) begin
        grant_vld = 1'b1;
        grant_idx = owner_q;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        sum = int'(rr_ptr_q) + i;
        if (sum >= N_REQ) sum = sum - N_REQ;
        cand = IDX_W'(sum);
        if (!grant_vld && bus.m_req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Lock FSM and round-robin pointer next state.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      owner_d  = grant_idx;
      state_d  = bus.m_req_lock[grant_idx] ? ST_LOCKED : ST_UNLOCKED;
    end
  end

  // Ready is one-hot on the granted requester; its operands go straight to the CFU.
  always_comb begin
    bus.m_req_ready     = '0;
    bus.cfu_req_valid   = grant_vld;
    bus.cfu_req_func_id = '0;
    bus.cfu_req_data0   = '0;
    bus.cfu_req_data1   = '0;
    if (grant_vld) bus.m_req_ready[grant_idx] = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_vld && grant_idx == IDX_W'(k)) begin
        bus.cfu_req_func_id = bus.m_req_func_id[k*CFU_FUNC_ID_W +: CFU_FUNC_ID_W];
        bus.cfu_req_data0   = bus.m_req_data0[k*CFU_REQ_DATA_W +: CFU_REQ_DATA_W];
        bus.cfu_req_data1   = bus.m_req_data1[k*CFU_REQ_DATA_W +: CFU_REQ_DATA_W];
      end
    end
  end

  // Tag pipeline advances every cycle in lockstep with the CFU pipeline.
  always_comb begin
    tag_vld_d[0] = grant_vld;
    tag_idx_d[0] = grant_idx;
    for (int i = 1; i < CFU_RESP_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  // Route a response to the issuer recorded in the last tag stage; untagged
  // responses are dropped and any valid/tag disagreement is latched.
  always_comb begin
    bus.m_resp_valid = '0;
    if (bus.cfu_resp_valid && tag_vld_q[CFU_RESP_LATENCY-1])
      bus.m_resp_valid[tag_idx_q[CFU_RESP_LATENCY-1]] = 1'b1;
    bus.m_resp_data   = bus.cfu_resp_data;
    bus.m_resp_err    = bus.cfu_resp_err;
    bus.m_resp_err_id = bus.cfu_resp_err_id;
    proto_err_d = proto_err_q |
                  (bus.cfu_resp_valid != tag_vld_q[CFU_RESP_LATENCY-1]);
  end

  // State, pointer, tag and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      tag_vld_q   <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < CFU_RESP_LATENCY; i++) tag_idx_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_vld_q   <= tag_vld_d;
      proto_err_q <= proto_err_d;
      for (int i = 0; i < CFU_RESP_LATENCY; i++) tag_idx_q[i] <= tag_idx_d[i];
    end
  end

  assign proto_err  = proto_err_q;
  assign dbg_locked = (state_q == ST_LOCKED);
  assign dbg_owner  = owner_q;
  assign dbg_rr_ptr = rr_ptr_q;

`ifdef CFU_ARB_STATS_EN
  logic [15:0] stat_q [N_REQ];
  logic [15:0] stat_d [N_REQ];

  // Saturating per-requester issue counters.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      stat_d[k] = stat_q[k];
      if (grant_vld && grant_idx == IDX_W'(k) && stat_q[k] != 16'hFFFF)
        stat_d[k] = stat_q[k] + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_REQ; k++) begin
      if (rst) stat_q[k] <= '0;
      else     stat_q[k] <= stat_d[k];
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    stat_issued = '0;
    for (int k = 0; k < N_REQ; k++) stat_issued[k*16 +: 16] = stat_q[k];
  end
`endif

endmodule
